// File: rtl/pc_stack.sv
// pc_stack: program counter with an integrated circular return-address stack.
// Per-cycle priority: reset > load > call > ret > inc > hold.
// Optional feature macro: PC_STACK_TRAP_EN
//   defined   -> call-when-full / ret-when-empty are rejected and set sticky err
//   undefined -> wrap mode: overflow overwrites oldest entry, underflow jumps to
//                RESET_VEC; err is tied low
module pc_stack #(
   parameter int unsigned      WIDTH     = 16,
   parameter int unsigned      DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in,
   input  logic                     load,
   input  logic                     call,
   input  logic                     ret,
   input  logic                     inc,
   output logic [WIDTH-1:0]         out,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     full,
   output logic                     empty,
   output logic                     err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = AW + 1;
   localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_LOAD,
      OP_CALL,
      OP_RET,
      OP_INC
   } op_e;

   op_e              op;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pc_plus1;
   logic [AW-1:0]    wp_q, wp_d;
   logic [AW-1:0]    rd_ptr;
   logic [DW-1:0]    cnt_q, cnt_d;
   logic             push;
   logic             is_full;
   logic             is_empty;
   logic [WIDTH-1:0] mem [DEPTH];

   assign pc_plus1 = pc_q + WIDTH'(1);
   assign rd_ptr   = wp_q - AW'(1);
   assign is_full  = (cnt_q == FULL_CNT);
   assign is_empty = (cnt_q == '0);

   assign out   = pc_q;
   assign depth = cnt_q;
   assign full  = is_full;
   assign empty = is_empty;

   // Priority decode: only the highest-priority request acts this cycle
   always_comb begin
      op = OP_HOLD;
      if (load)
         op = OP_LOAD;
      else if (call)
         op = OP_CALL;
      else if (ret)
         op = OP_RET;
      else if (inc)
         op = OP_INC;
   end

`ifdef PC_STACK_TRAP_EN
   logic trap;
   logic err_q;

   // Next PC / stack pointer / occupancy; overflow and underflow are rejected
   always_comb begin
      pc_d  = pc_q;
      wp_d  = wp_q;
      cnt_d = cnt_q;
      push  = 1'b0;
      trap  = 1'b0;
      case (op)
         OP_LOAD: pc_d = in;
         OP_CALL: begin
            if (is_full) begin
               trap = 1'b1;
            end else begin
               push  = 1'b1;
               pc_d  = in;
               wp_d  = wp_q + AW'(1);
               cnt_d = cnt_q + DW'(1);
            end
         end
         OP_RET: begin
            if (is_empty) begin
               trap = 1'b1;
            end else begin
               pc_d  = mem[rd_ptr];
               wp_d  = rd_ptr;
               cnt_d = cnt_q - DW'(1);
            end
         end
         OP_INC:  pc_d = pc_plus1;
         default: pc_d = pc_q;
      endcase
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if (trap)
         err_q <= 1'b1;
   end

   assign err = err_q;
`else
   // Next PC / stack pointer / occupancy; overflow overwrites oldest entry
   always_comb begin
      pc_d  = pc_q;
      wp_d  = wp_q;
      cnt_d = cnt_q;
      push  = 1'b0;
      case (op)
         OP_LOAD: pc_d = in;
         OP_CALL: begin
            // Pointer always advances; occupancy saturates at DEPTH so the
            // oldest entry is silently replaced.
            push = 1'b1;
            pc_d = in;
            wp_d = wp_q + AW'(1);
            if (!is_full)
               cnt_d = cnt_q + DW'(1);
         end
         OP_RET: begin
            if (is_empty) begin
               pc_d = RESET_VEC;
            end else begin
               pc_d  = mem[rd_ptr];
               wp_d  = rd_ptr;
               cnt_d = cnt_q - DW'(1);
            end
         end
         OP_INC:  pc_d = pc_plus1;
         default: pc_d = pc_q;
      endcase
   end

   assign err = 1'b0;
`endif

   // PC, write pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_VEC;
         wp_q  <= '0;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
      end
   end

   // Return-address storage; contents survive reset, only occupancy is cleared
   always_ff @(posedge clk) begin
      if (push && !reset)
         mem[wp_q] <= pc_plus1;
   end

endmodule

// File: tb/tb_pc_stack.sv
// Testbench for pc_stack: directed test-plan steps followed by random
// commands, all checked against a queue-based return-stack model.
// Honours PC_STACK_TRAP_EN so the same bench covers both builds.
module tb_pc_stack;

   localparam int unsigned W = 16;
   localparam int unsigned D = 8;
   localparam logic [W-1:0] RV = 16'h0000;

   logic         clk = 1'b0;
   logic         reset, load, call, ret, inc;
   logic [W-1:0] din;
   logic [W-1:0] dout;
   logic [3:0]   ddepth;
   logic         dfull, dempty, derr;

   int tests = 0;
   int fails = 0;

   // Reference state: PC, return addresses (back = top), sticky error
   logic [W-1:0] m_pc;
   logic [W-1:0] m_q [$];
   logic         m_err;

   pc_stack #(
      .WIDTH(W),
      .DEPTH(D),
      .RESET_VEC(RV)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in(din),
      .load(load),
      .call(call),
      .ret(ret),
      .inc(inc),
      .out(dout),
      .depth(ddepth),
      .full(dfull),
      .empty(dempty),
      .err(derr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply the command rules to the model using the inputs about to be sampled
   task automatic model_step();
      logic [W-1:0] nxt;
      nxt = m_pc + 16'd1;
      if (reset) begin
         m_pc = RV;
         m_q.delete();
         m_err = 1'b0;
      end else if (load) begin
         m_pc = din;
      end else if (call) begin
         if (m_q.size() == D) begin
`ifdef PC_STACK_TRAP_EN
            m_err = 1'b1;
`else
            void'(m_q.pop_front());
            m_q.push_back(nxt);
            m_pc = din;
`endif
         end else begin
            m_q.push_back(nxt);
            m_pc = din;
         end
      end else if (ret) begin
         if (m_q.size() == 0) begin
`ifdef PC_STACK_TRAP_EN
            m_err = 1'b1;
`else
            m_pc = RV;
`endif
         end else begin
            m_pc = m_q.pop_back();
         end
      end else if (inc) begin
         m_pc = nxt;
      end
   endtask

   // One clock: drive, update model, sample 1 time unit after the edge, compare
   task automatic cyc(input logic r, input logic l, input logic c, input logic t,
                      input logic i, input logic [W-1:0] v);
      reset = r; load = l; call = c; ret = t; inc = i; din = v;
      @(posedge clk);
      model_step();
      #1;
      chk("out",   32'(dout),   32'(m_pc));
      chk("depth", 32'(ddepth), 32'(m_q.size()));
      chk("full",  32'(dfull),  32'(m_q.size() == D));
      chk("empty", 32'(dempty), 32'(m_q.size() == 0));
      chk("err",   32'(derr),   32'(m_err));
      reset = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; inc = 1'b0;
   endtask

   initial begin
      m_pc = RV;
      m_err = 1'b0;
      reset = 1'b1; load = 1'b0; call = 1'b0; ret = 1'b0; inc = 1'b0; din = '0;

      // Reset state
      cyc(1, 0, 0, 0, 0, 16'h0);
      cyc(1, 0, 0, 0, 0, 16'h0);
      chk("rst_out", 32'(dout), 32'(RV));
      chk("rst_depth", 32'(ddepth), 32'd0);

      // Increment, load, load beats inc
      cyc(0, 0, 0, 0, 1, 16'h0); chk("inc1", 32'(dout), 32'h1);
      cyc(0, 0, 0, 0, 1, 16'h0); chk("inc2", 32'(dout), 32'h2);
      cyc(0, 0, 0, 0, 1, 16'h0); chk("inc3", 32'(dout), 32'h3);
      cyc(0, 1, 0, 0, 0, 16'h1234); chk("load", 32'(dout), 32'h1234);
      cyc(0, 1, 0, 0, 1, 16'h0050); chk("load_inc", 32'(dout), 32'h0050);

      // Address wrap
      cyc(0, 1, 0, 0, 0, 16'hFFFF);
      cyc(0, 0, 0, 0, 1, 16'h0); chk("inc_wrap", 32'(dout), 32'h0);

      // Nested calls
      cyc(0, 1, 0, 0, 0, 16'h0010);
      cyc(0, 0, 1, 0, 0, 16'h0100);
      cyc(0, 0, 1, 0, 0, 16'h0200); chk("nest_depth", 32'(ddepth), 32'd2);
      cyc(0, 0, 0, 1, 0, 16'h0);    chk("nest_ret1", 32'(dout), 32'h0101);
      cyc(0, 0, 0, 1, 0, 16'h0);    chk("nest_ret2", 32'(dout), 32'h0011);
      chk("nest_empty", 32'(dempty), 32'd1);

      // Overflow: nine calls from 0x0000
      cyc(0, 1, 0, 0, 0, 16'h0000);
      for (int k = 1; k <= 9; k++) cyc(0, 0, 1, 0, 0, 16'(k * 16'h0100));
`ifdef PC_STACK_TRAP_EN
      chk("ovf_out", 32'(dout), 32'h0800);
      chk("ovf_err", 32'(derr), 32'd1);
      cyc(0, 0, 0, 1, 0, 16'h0); chk("ovf_ret", 32'(dout), 32'h0701);
`else
      chk("ovf_full", 32'(dfull), 32'd1);
      chk("ovf_depth", 32'(ddepth), 32'd8);
      for (int k = 8; k >= 1; k--) begin
         cyc(0, 0, 0, 1, 0, 16'h0);
         chk("ovf_ret", 32'(dout), 32'(k * 16'h0100 + 16'h0001));
      end
      cyc(0, 0, 0, 1, 0, 16'h0); chk("unf_ret", 32'(dout), 32'(RV));
`endif
      cyc(1, 0, 0, 0, 0, 16'h0);

      // Call and ret together: call wins
      cyc(0, 1, 0, 0, 0, 16'h0020);
      cyc(0, 0, 1, 1, 0, 16'h0300); chk("cr_out", 32'(dout), 32'h0300);
      chk("cr_depth", 32'(ddepth), 32'd1);
      cyc(0, 0, 0, 1, 0, 16'h0);    chk("cr_top", 32'(dout), 32'h0021);

      // Load with call: load wins, no push
      cyc(0, 1, 1, 0, 0, 16'h0444); chk("lc_depth", 32'(ddepth), 32'd0);

      // Reset mid-sequence
      cyc(0, 1, 0, 0, 0, 16'h0000);
      cyc(0, 0, 1, 0, 0, 16'h0100);
      cyc(0, 0, 1, 0, 0, 16'h0200);
      cyc(0, 0, 1, 0, 0, 16'h0300);
      cyc(1, 0, 0, 0, 0, 16'h0);
      chk("mid_out", 32'(dout), 32'(RV));
      chk("mid_depth", 32'(ddepth), 32'd0);
      chk("mid_err", 32'(derr), 32'd0);
      cyc(0, 0, 0, 1, 0, 16'h0);
`ifdef PC_STACK_TRAP_EN
      chk("mid_ret_err", 32'(derr), 32'd1);
`else
      chk("mid_ret", 32'(dout), 32'(RV));
`endif

      // Random commands against the model
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 8,
             $urandom_range(0, 99) < 40,
             $urandom_range(0, 99) < 40,
             $urandom_range(0, 99) < 50,
             16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
